cnt8_state_reg: RTL and testbench
=================================

# cnt8_state_reg

Registered state stage for the 8-bit preloadable down-counter datapath. Holds the counter bits that the combinational next-state logic consumes. Provides a two-source parallel preload, enable-gated decrement, and a small run-control FSM. Also generates the terminal-count flag and a one-cycle completion pulse for the downstream sequencer.

## Interface
- `WIDTH`, default 8: counter and preload bus width.
- `RELOAD`, default 0: when 1, the counter reloads automatically from the last loaded value on completion.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clr` input 1: synchronous clear; highest functional priority.
- `ld` input 1: parallel preload request.
- `sel` input 1: preload source select; 0 = `a_val`, 1 = `b_val`.
- `a_val` input WIDTH: preload source A.
- `b_val` input WIDTH: preload source B.
- `start` input 1: begin or resume counting.
- `stop` input 1: pause counting.
- `en` input 1: count enable (borrow-in); decrement only when high in RUN.
- `cnt` output WIDTH: registered counter value.
- `tc` output 1: terminal count, `cnt == 0`; decoded from the register only, no input-to-output path.
- `done` output 1: registered one-cycle completion pulse.
- `busy` output 1: high in RUN or HOLD.
- `state` output 2: FSM encoding. IDLE=00, RUN=01, HOLD=10, DONE=11.

## Operation
- **Registers:** `cnt`, `rl_val` (last loaded value), `state`, `done`.
- **Reset (async, rst_n low):** `cnt`=0, `rl_val`=0, `state`=IDLE, `done`=0. Takes effect immediately, mid-count included. `busy`=0, `tc`=1 while held.
- **Priority per edge:** `clr` > `ld` > `stop` > `start` > count.
- **clr:** `cnt`=0, `state`=IDLE, `done`=0. `rl_val` is unchanged.
- **ld, any state:**
  - `cnt` and `rl_val` take `sel ? b_val : a_val`.
  - `state`=IDLE, or RUN if `start` is high in the same cycle and the loaded value is ≠0.
  - An in-progress count is abandoned with no `done`.
- **IDLE / DONE + start:** RUN if `cnt`≠0. If `cnt`==0, go to DONE and pulse `done`.
- **RUN + stop:** HOLD, `cnt` frozen. **HOLD + start:** RUN. `stop` in IDLE or DONE is ignored.
- **RUN, en=1:**
  - `cnt`>1: `cnt`=`cnt`−1.
  - `cnt`==1: `cnt`=0, `state`=DONE, `done`=1 for exactly the next cycle.
- **RUN, en=0:** hold.
- `en` is ignored outside RUN. The counter never decrements below 0 and never wraps.
- **RELOAD=1, on the RUN→DONE transition:**
  - Same edge as `done` is set: `cnt`=`rl_val` and `state`=RUN, instead of 0/DONE, provided `rl_val`≠0.
  - If `rl_val`==0: enter DONE, no reload, `done` pulses once.
- **Arithmetic:** unsigned, WIDTH-bit. `done` defaults to 0 on every edge unless set by a completion event.

## Timing
- **Load latency:** 1 cycle. `ld` high at edge k makes `cnt` valid after edge k.
- **Start latency:** `start` at edge k puts `state`=RUN after edge k. The first decrement occurs at the first later edge with `en`=1.
- **Count-down length:** preload N, `en` held high → `cnt` reaches 0 and `done` is high in the cycle after the N-th RUN edge. Total is N+1 edges from the start edge.
- **Reload timing (RELOAD=1):**
  - The pulse after the reload edge coincides with `cnt`=`rl_val`.
  - Periodic `done` has period N cycles with `en` constantly high.
- **Simultaneous events:**
  - `ld`+`clr`: clear wins.
  - `stop`+`start` in RUN: HOLD.
  - `ld` in the completion cycle: load wins, no `done`.
- **Output behaviour:** outputs are glitch-free registers except `tc`, `busy` and `state`. Those are decoded from registers only.

## Test plan
- **Reset mid-count:** load 0x05, start, 2 enabled edges (`cnt`=0x03), pulse `rst_n` low asynchronously → immediately `cnt`=0, `state`=00, `done`=0, `tc`=1.
- **Source select and count:**
  - Stimulus: `a_val`=0x10, `b_val`=0x03, `sel`=1, `ld`; then `start`, `en`=1.
  - `cnt` sequence: 03, 02, 01, 00.
  - `done` is high exactly one cycle, with `state`=11.
- **Enable gating and pause:**
  - Load 0x04, start, then `en` pattern 1,0,1, then `stop`.
  - Expected `cnt`: 03, 03, 02, then `state`=10 (HOLD).
  - With `stop` low, `start` resumes to `state`=01; `cnt`=02 stays until the next enabled edge.
- **Zero start:** `ld` 0x00 then `start` → `state`=11 next edge, single `done` pulse, `cnt` stays 0.
- **Auto-reload (RELOAD=1):** load 0x03, start, `en`=1 for 9 edges → `done` pulses 3 times at a 3-cycle period and `cnt` cycles 02, 01, 03. With `rl_val`=0 → exactly one `done`.
- **Priority collisions:**
  - `clr`+`ld` on the same edge → `cnt`=0.
  - `ld` 0x07 on the edge where `cnt` goes 1→0 in RUN → `cnt`=0x07, `state`=00, no `done`.

Source files
------------

// File: rtl/cnt8_state_reg.sv
// Registered state stage of the preloadable down-counter: preload mux, gated
// decrement, run-control FSM, terminal-count flag and completion pulse.
//
// state | meaning
// IDLE  | loaded or cleared, waiting for start
// RUN   | decrementing on enabled edges
// HOLD  | paused by stop, count frozen
// DONE  | count reached zero, waiting for start or a new load
module cnt8_state_reg #(
  parameter int WIDTH  = 8,
  parameter bit RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic             sel,
  input  logic [WIDTH-1:0] a_val,
  input  logic [WIDTH-1:0] b_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           st_q, st_d;
  logic [WIDTH-1:0] cnt_d, rl_q, rl_d, ld_val;
  logic             done_d;

  assign ld_val = sel ? b_val : a_val;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt;
    rl_d   = rl_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
      st_d  = IDLE;
    end else if (ld) begin
      cnt_d = ld_val;
      rl_d  = ld_val;
      st_d  = (start && (ld_val != '0)) ? RUN : IDLE;
    end else begin
      unique case (st_q)
        IDLE, DONE: begin
          if (start) begin
            if (cnt != '0) begin
              st_d = RUN;
            end else begin
              st_d   = DONE;
              done_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!stop && start) st_d = RUN;
        end
        RUN: begin
          if (stop) begin
            st_d = HOLD;
          end else if (en) begin
            if (cnt > ONE) begin
              cnt_d = cnt - ONE;
            end else if (cnt == ONE) begin
              done_d = 1'b1;
              // Auto-reload keeps running only when there is a nonzero value to restart from.
              if (RELOAD && (rl_q != '0)) begin
                cnt_d = rl_q;
              end else begin
                cnt_d = '0;
                st_d  = DONE;
              end
            end
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      rl_q <= '0;
      st_q <= IDLE;
      done <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      rl_q <= rl_d;
      st_q <= st_d;
      done <= done_d;
    end
  end

  assign tc    = (cnt == '0);
  assign busy  = (st_q == RUN) || (st_q == HOLD);
  assign state = st_q;

endmodule

// File: tb/tb_cnt8_state_reg.sv
// Bench for cnt8_state_reg: one instance without and one with auto-reload,
// directed scenarios then random stimulus, all checked against a behavioural model.
module tb_cnt8_state_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 0, ld = 0, sel = 0, start = 0, stop = 0, en = 0;
  logic [7:0] a_val = 0, b_val = 0;

  logic [7:0] cnt [2];
  logic       tc [2], done [2], busy [2];
  logic [1:0] state [2];

  int n_chk = 0;
  int n_pass = 0;

  // model: state 0 idle, 1 run, 2 hold, 3 done
  int m_cnt [2], m_rl [2], m_st [2], m_done [2];
  int pulses [2];

  always #5 clk = ~clk;

  cnt8_state_reg #(.WIDTH(8), .RELOAD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .sel(sel), .a_val(a_val), .b_val(b_val),
    .start(start), .stop(stop), .en(en), .cnt(cnt[0]), .tc(tc[0]), .done(done[0]),
    .busy(busy[0]), .state(state[0]));

  cnt8_state_reg #(.WIDTH(8), .RELOAD(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .sel(sel), .a_val(a_val), .b_val(b_val),
    .start(start), .stop(stop), .en(en), .cnt(cnt[1]), .tc(tc[1]), .done(done[1]),
    .busy(busy[1]), .state(state[1]));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_cnt[r] = 0; m_rl[r] = 0; m_st[r] = 0; m_done[r] = 0;
    end
  endtask

  task automatic model_edge(input int r);
    int v;
    m_done[r] = 0;
    if (clr) begin
      m_cnt[r] = 0; m_st[r] = 0;
    end else if (ld) begin
      v = sel ? int'(b_val) : int'(a_val);
      m_cnt[r] = v; m_rl[r] = v;
      m_st[r] = (start && v != 0) ? 1 : 0;
    end else if (stop && (m_st[r] == 1 || m_st[r] == 2)) begin
      m_st[r] = 2;
    end else if (start && (m_st[r] == 0 || m_st[r] == 3)) begin
      if (m_cnt[r] != 0) m_st[r] = 1;
      else begin m_st[r] = 3; m_done[r] = 1; end
    end else if (start && m_st[r] == 2) begin
      m_st[r] = 1;
    end else if (m_st[r] == 1 && en) begin
      if (m_cnt[r] > 1) m_cnt[r]--;
      else if (m_cnt[r] == 1) begin
        m_done[r] = 1;
        if (r == 1 && m_rl[r] != 0) m_cnt[r] = m_rl[r];
        else begin m_cnt[r] = 0; m_st[r] = 3; end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("%s.cnt%0d", tag, r), int'(cnt[r]), m_cnt[r]);
      chk($sformatf("%s.state%0d", tag, r), int'(state[r]), m_st[r]);
      chk($sformatf("%s.done%0d", tag, r), int'(done[r]), m_done[r]);
      chk($sformatf("%s.tc%0d", tag, r), int'(tc[r]), int'(m_cnt[r] == 0));
      chk($sformatf("%s.busy%0d", tag, r), int'(busy[r]), int'(m_st[r] == 1 || m_st[r] == 2));
    end
  endtask

  // one clock edge with the currently driven inputs, then check and idle the inputs
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all(tag);
    for (int r = 0; r < 2; r++) pulses[r] += int'(done[r]);
    clr = 0; ld = 0; start = 0; stop = 0; en = 0;
  endtask

  task automatic load(input logic [7:0] v, input logic st);
    ld = 1; sel = 0; a_val = v; start = st;
    cyc("load");
  endtask

  initial begin
    model_reset();
    pulses[0] = 0; pulses[1] = 0;
    #12;
    compare_all("reset");
    rst_n = 1;
    @(negedge clk);

    // reset mid-count
    load(8'h05, 1'b0);
    start = 1; cyc("rst_start");
    en = 1; cyc("rst_en1");
    en = 1; cyc("rst_en2");
    chk("rst_precnt", int'(cnt[0]), 3);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("async_cnt", int'(cnt[0]), 0);
    chk("async_state", int'(state[0]), 0);
    chk("async_done", int'(done[0]), 0);
    chk("async_tc", int'(tc[0]), 1);
    compare_all("async");
    #1 rst_n = 1;

    // source select and count
    ld = 1; sel = 1; a_val = 8'h10; b_val = 8'h03; cyc("sel_ld");
    chk("sel_cnt", int'(cnt[0]), 3);
    start = 1; cyc("sel_start");
    pulses[0] = 0;
    for (int i = 2; i >= 0; i--) begin
      en = 1; cyc("sel_cnt");
      chk("sel_seq", int'(cnt[0]), i);
    end
    chk("sel_done_state", int'(state[0]), 3);
    en = 1; cyc("sel_after");
    chk("sel_one_pulse", pulses[0], 1);

    // enable gating and pause
    load(8'h04, 1'b0);
    start = 1; cyc("eg_start");
    en = 1; cyc("eg_e1"); chk("eg_c1", int'(cnt[0]), 3);
    en = 0; cyc("eg_e0"); chk("eg_c2", int'(cnt[0]), 3);
    en = 1; cyc("eg_e1b"); chk("eg_c3", int'(cnt[0]), 2);
    stop = 1; en = 1; cyc("eg_stop"); chk("eg_hold", int'(state[0]), 2);
    start = 1; cyc("eg_resume"); chk("eg_run", int'(state[0]), 1);
    chk("eg_cnt_kept", int'(cnt[0]), 2);

    // stop and start together in RUN
    stop = 1; start = 1; cyc("ss_both");
    chk("ss_hold", int'(state[0]), 2);

    // zero start
    load(8'h00, 1'b0);
    pulses[0] = 0;
    start = 1; cyc("zs_start");
    chk("zs_state", int'(state[0]), 3);
    chk("zs_done", int'(done[0]), 1);
    en = 1; cyc("zs_after");
    chk("zs_pulses", pulses[0], 1);
    chk("zs_cnt", int'(cnt[0]), 0);

    // auto-reload
    load(8'h03, 1'b1);
    pulses[0] = 0; pulses[1] = 0;
    for (int i = 0; i < 9; i++) begin
      en = 1; cyc("rl_run");
      chk("rl_seq", int'(cnt[1]), (i % 3 == 2) ? 3 : 2 - (i % 3));
    end
    chk("rl_pulses1", pulses[1], 3);
    chk("rl_pulses0", pulses[0], 1);
    load(8'h00, 1'b1);
    pulses[1] = 0;
    start = 1; cyc("rl0_start");
    for (int i = 0; i < 4; i++) begin en = 1; cyc("rl0_run"); end
    chk("rl0_pulses", pulses[1], 1);

    // collisions
    load(8'h09, 1'b0);
    clr = 1; ld = 1; a_val = 8'h22; cyc("col_clr_ld");
    chk("col_clr_cnt", int'(cnt[0]), 0);
    load(8'h01, 1'b1);
    ld = 1; sel = 0; a_val = 8'h07; en = 1; cyc("col_ld_done");
    chk("col_cnt", int'(cnt[0]), 7);
    chk("col_state", int'(state[0]), 0);
    chk("col_done", int'(done[0]), 0);

    // random
    for (int i = 0; i < 600; i++) begin
      clr   = ($urandom_range(0, 39) == 0);
      ld    = ($urandom_range(0, 9) == 0);
      sel   = 1'($urandom);
      a_val = 8'($urandom_range(0, 5));
      b_val = 8'($urandom_range(0, 5));
      en    = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0, 1: start = 1;
        2:    stop = 1;
        default: ;
      endcase
      cyc("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
